data_mem_sys: RTL and testbench

Data-side memory subsystem that sits directly downstream of the single-cycle RISC-V core. It consumes the core's `dataadr`/`writedata`/`memwrite` outputs and returns `readdata` in the same cycle. It contains word-addressed data RAM plus a small memory-mapped peripheral block: a GPIO output register and a prescaled 32-bit timer with compare match and interrupt flag.

---
 rtl/data_mem_pkg.sv | 29 ++
 rtl/mmio_timer.sv | 101 ++++++++++
 rtl/data_mem_sys.sv | 84 ++++++++
 tb/tb_data_mem_sys.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg
//   Shared constants and types for the data-side memory subsystem:
//   MMIO base address, register offsets, CTRL bit positions and the
//   CMP reset value. Imported by mmio_timer and data_mem_sys.
package data_mem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    localparam logic [3:0] OFF_GPIO  = 4'h0;
    localparam logic [3:0] OFF_COUNT = 4'h4;
    localparam logic [3:0] OFF_CMP   = 4'h8;
    localparam logic [3:0] OFF_CTRL  = 4'hC;

    // Register select is the word index within the MMIO block.
    typedef enum logic [1:0] {
        REG_GPIO  = OFF_GPIO[3:2],
        REG_COUNT = OFF_COUNT[3:2],
        REG_CMP   = OFF_CMP[3:2],
        REG_CTRL  = OFF_CTRL[3:2]
    } mmio_reg_e;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_FLAG = 2;
    localparam int CTRL_IE   = 3;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer
//   Prescaled 32-bit timer with compare match and sticky interrupt flag.
//   Holds the prescaler, COUNT, CMP and CTRL registers.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   i_we       : write strobe for the selected timer register
//   i_sel      : register select (GPIO select is ignored here)
//   i_wdata    : write data
//   o_rdata    : read mux of the selected register (0 for GPIO)
//   o_irq      : flag & ie
module mmio_timer
    import data_mem_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  mmio_reg_e   i_sel,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

    logic [PCNT_W-1:0] r_pcnt;
    logic [31:0]       r_count;
    logic [31:0]       r_cmp;
    logic              r_en;
    logic              r_autoreload;
    logic              r_flag;
    logic              r_ie;

    logic w_tick;
    logic w_match;
    logic w_wr_count;
    logic w_wr_cmp;
    logic w_wr_ctrl;

    assign w_tick     = r_en && (r_pcnt == PCNT_LAST);
    assign w_match    = w_tick && (r_count == r_cmp);
    assign w_wr_count = i_we && (i_sel == REG_COUNT);
    assign w_wr_cmp   = i_we && (i_sel == REG_CMP);
    assign w_wr_ctrl  = i_we && (i_sel == REG_CTRL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt       <= '0;
            r_count      <= '0;
            r_cmp        <= CMP_RESET;
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_flag       <= 1'b0;
            r_ie         <= 1'b0;
        end else begin
            // Prescaler phase is independent of COUNT writes.
            if (!r_en || w_tick) r_pcnt <= '0;
            else                 r_pcnt <= r_pcnt + PCNT_ONE;

            // A software COUNT write wins over tick increment or reload.
            if (w_wr_count)
                r_count <= i_wdata;
            else if (w_tick)
                r_count <= (w_match && r_autoreload) ? 32'd0 : r_count + 32'd1;

            if (w_wr_cmp) r_cmp <= i_wdata;

            if (w_wr_ctrl) begin
                r_en         <= i_wdata[CTRL_EN];
                r_autoreload <= i_wdata[CTRL_AR];
                r_ie         <= i_wdata[CTRL_IE];
            end

            // Hardware set has priority over the write-1-to-clear.
            if (w_match)
                r_flag <= 1'b1;
            else if (w_wr_ctrl && i_wdata[CTRL_FLAG])
                r_flag <= 1'b0;
        end
    end

    // NOTE: every output of this combinational block gets a default first so
    // no path through the case can infer a latch.
    always_comb begin
        o_rdata = '0;
        unique case (i_sel)
            REG_COUNT: o_rdata = r_count;
            REG_CMP:   o_rdata = r_cmp;
            REG_CTRL:  o_rdata = {28'd0, r_ie, r_flag, r_autoreload, r_en};
            default:   o_rdata = '0;
        endcase
    end

    assign o_irq = r_flag & r_ie;

endmodule

// File: rtl/data_mem_sys.sv
// data_mem_sys
//   Data-side memory subsystem for the single-cycle core: word-addressed
//   RAM (asynchronous read, write on edge) plus an MMIO block containing a
//   GPIO output register and the prescaled timer.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   dataadr    : byte address ([31]=0 RAM, [31]=1 MMIO; [1:0] ignored)
//   writedata  : store data
//   memwrite   : store strobe
//   readdata   : combinational load data
//   gpio_out   : GPIO output register
//   timer_irq  : timer interrupt (flag & ie)
module data_mem_sys
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int PRESCALE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] r_ram [DEPTH_WORDS];
    logic [31:0] r_gpio;

    logic          w_is_mmio;
    logic          w_mmio_hit;
    logic          w_mmio_we;
    mmio_reg_e     w_sel;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_timer_rdata;
    logic          w_unused;

    assign w_is_mmio  = dataadr[31];
    // Only the 16-byte window at the base decodes; the rest of MMIO space reads 0.
    assign w_mmio_hit = (dataadr[31:4] == MMIO_BASE[31:4]);
    assign w_mmio_we  = memwrite && w_mmio_hit;
    assign w_sel      = mmio_reg_e'(dataadr[3:2]);
    // Upper address bits are dropped so RAM aliases across the low half.
    assign w_ram_idx  = dataadr[AW+1:2];
    assign w_unused   = ^dataadr[1:0];

    // NOTE: the RAM array has no reset so it maps onto plain memory; its
    // contents survive rst.
    always_ff @(posedge clk) begin
        if (memwrite && !w_is_mmio) r_ram[w_ram_idx] <= writedata;
    end

    always_ff @(posedge clk) begin
        if (rst)                                  r_gpio <= '0;
        else if (w_mmio_we && (w_sel == REG_GPIO)) r_gpio <= writedata;
    end

    mmio_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mmio_we),
        .i_sel   (w_sel),
        .i_wdata (writedata),
        .o_rdata (w_timer_rdata),
        .o_irq   (timer_irq)
    );

    always_comb begin
        readdata = '0;
        if (!w_is_mmio)
            readdata = r_ram[w_ram_idx];
        else if (w_mmio_hit)
            readdata = (w_sel == REG_GPIO) ? r_gpio : w_timer_rdata;
    end

    assign gpio_out = r_gpio;

endmodule

// File: tb/tb_data_mem_sys.sv
// tb_data_mem_sys
//   Drives two instances (PRESCALE=4 and PRESCALE=1, DEPTH_WORDS=64) with the
//   same stimulus. A behavioural model predicts each cycle's load data, GPIO
//   and IRQ; predictions go into a queue and a monitor on the falling edge
//   pops and compares them against both instances.
module tb_data_mem_sys;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] rd4, rd1, gpio4, gpio1;
    logic        irq4, irq1;

    always #5 clk = ~clk;

    data_mem_sys #(.DEPTH_WORDS(DEPTH), .PRESCALE(4)) u_dut4 (
        .clk(clk), .rst(rst), .dataadr(dataadr), .writedata(writedata),
        .memwrite(memwrite), .readdata(rd4), .gpio_out(gpio4), .timer_irq(irq4)
    );

    data_mem_sys #(.DEPTH_WORDS(DEPTH), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .dataadr(dataadr), .writedata(writedata),
        .memwrite(memwrite), .readdata(rd1), .gpio_out(gpio1), .timer_irq(irq1)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] count;
        logic [31:0] cmp;
        logic [31:0] gpio;
        bit          en, ar, flag, ie;
        int          phase;
    } tmodel_t;

    typedef struct {
        bit          chk_rd;
        logic [31:0] addr;
        logic [31:0] exp_rd4, exp_rd1, exp_gpio;
        bit          exp_irq4, exp_irq1;
    } exp_t;

    tmodel_t     m4, m1;
    logic [31:0] ram  [DEPTH];
    bit          ramv [DEPTH];
    exp_t        q [$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int ram_index(logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit in_window(logic [31:0] a);
        return (a / 16) == 32'h0800_0000;
    endfunction

    function automatic tmodel_t reset_model();
        tmodel_t m;
        m.count = 0; m.cmp = 32'hFFFF_FFFF; m.gpio = 0;
        m.en = 0; m.ar = 0; m.flag = 0; m.ie = 0; m.phase = 0;
        return m;
    endfunction

    function automatic logic [31:0] model_read(tmodel_t m, logic [31:0] a);
        if (a < 32'h8000_0000) return ram[ram_index(a)];
        if (!in_window(a)) return 0;
        case ((a % 16) / 4)
            0: return m.gpio;
            1: return m.count;
            2: return m.cmp;
            default: return 32'(m.en) + 32'(m.ar) * 2 + 32'(m.flag) * 4 + 32'(m.ie) * 8;
        endcase
    endfunction

    function automatic tmodel_t model_step(tmodel_t s, int ps, bit r,
                                           logic [31:0] a, logic [31:0] w, bit we);
        tmodel_t n;
        bit      tick, hit_match;
        if (r) return reset_model();
        n         = s;
        tick      = s.en && (s.phase == ps - 1);
        hit_match = tick && (s.count == s.cmp);
        n.phase   = (s.en && !tick) ? s.phase + 1 : 0;
        if (tick) begin
            if (hit_match) n.flag = 1;
            n.count = (hit_match && s.ar) ? 0 : s.count + 1;
        end
        if (we && in_window(a)) begin
            case ((a % 16) / 4)
                0: n.gpio = w;
                1: n.count = w;
                2: n.cmp = w;
                default: begin
                    n.en = w[0]; n.ar = w[1]; n.ie = w[3];
                    if (w[2] && !hit_match) n.flag = 0;
                end
            endcase
        end
        return n;
    endfunction

    // ---------------- check / monitor ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_rd) begin
                check($sformatf("rd_p4@%08h", e.addr), rd4, e.exp_rd4);
                check($sformatf("rd_p1@%08h", e.addr), rd1, e.exp_rd1);
            end
            check("gpio_p4", gpio4, e.exp_gpio);
            check("gpio_p1", gpio1, e.exp_gpio);
            check("irq_p4", {31'd0, irq4}, {31'd0, e.exp_irq4});
            check("irq_p1", {31'd0, irq1}, {31'd0, e.exp_irq1});
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_cycle(bit r, logic [31:0] a, logic [31:0] w, bit we);
        exp_t e;
        rst = r; dataadr = a; writedata = w; memwrite = we;
        e.addr     = a;
        e.chk_rd   = (a >= 32'h8000_0000) || ramv[ram_index(a)];
        e.exp_rd4  = model_read(m4, a);
        e.exp_rd1  = model_read(m1, a);
        e.exp_gpio = m4.gpio;
        e.exp_irq4 = m4.flag && m4.ie;
        e.exp_irq1 = m1.flag && m1.ie;
        q.push_back(e);
        @(posedge clk);
        m4 = model_step(m4, 4, r, a, w, we);
        m1 = model_step(m1, 1, r, a, w, we);
        if (we && a < 32'h8000_0000) begin
            ram[ram_index(a)]  = w;
            ramv[ram_index(a)] = 1;
        end
        #1;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] w);
        do_cycle(0, a, w, 1);
    endtask

    task automatic rd(logic [31:0] a);
        do_cycle(0, a, $urandom, 0);
    endtask

    localparam logic [31:0] A_GPIO = 32'h8000_0000;
    localparam logic [31:0] A_CNT  = 32'h8000_0004;
    localparam logic [31:0] A_CMP  = 32'h8000_0008;
    localparam logic [31:0] A_CTRL = 32'h8000_000C;

    initial begin
        logic [31:0] a, w;
        rst = 1; dataadr = 0; writedata = 0; memwrite = 0;
        for (int i = 0; i < DEPTH; i++) ramv[i] = 0;
        @(posedge clk);
        m4 = reset_model();
        m1 = reset_model();
        #1;
        do_cycle(1, A_GPIO, 0, 0);

        // Reset values of every MMIO register.
        rd(A_GPIO); rd(A_CNT); rd(A_CMP); rd(A_CTRL);

        // RAM store, load, alias and ignored low bits.
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010); rd(32'h0000_0110); rd(32'h0000_0013);

        // Autoreload with compare, observe COUNT every cycle.
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'hB);
        for (int i = 0; i < 14; i++) rd(A_CNT);
        rd(A_CTRL);
        wr(A_CTRL, 32'hF);
        rd(A_CTRL); rd(A_CTRL);

        // Wrap from 0xFFFF_FFFF without flag, then match without autoreload.
        wr(A_CTRL, 32'h4);
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h9);
        for (int i = 0; i < 10; i++) rd(A_CNT);
        rd(A_CTRL);

        // W1C landing on a match tick; COUNT write landing on a tick.
        wr(A_CTRL, 32'h4);
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'd3);
        wr(A_CTRL, 32'h9);
        rd(A_CNT); rd(A_CNT);
        wr(A_CTRL, 32'hD);
        rd(A_CTRL);
        wr(A_CNT, 32'h100);
        rd(A_CNT);

        // Unmapped MMIO reads 0 and ignores writes.
        wr(32'h8000_0010, 32'h1234_5678);
        rd(32'h8000_0010); rd(32'hC000_0004);

        // Reset while running: MMIO back to defaults, RAM retained.
        wr(A_GPIO, 32'h55);
        rd(A_CNT);
        do_cycle(1, A_GPIO, 0, 0);
        rd(A_GPIO); rd(A_CNT); rd(A_CMP); rd(A_CTRL);
        rd(32'h0000_0010);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    a = {1'b0, 23'($urandom_range(0, 3)), 8'($urandom)};
                    w = $urandom;
                end
                2: begin a = A_GPIO | 32'($urandom_range(0, 3)); w = $urandom; end
                3: begin
                    a = A_CNT;
                    w = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 10));
                end
                4: begin a = A_CMP; w = 32'($urandom_range(0, 12)); end
                5, 6: begin a = A_CTRL; w = $urandom; end
                7: begin a = 32'h8000_0000 | (32'($urandom_range(1, 255)) << 4); w = $urandom; end
                default: begin
                    a = A_CNT | 32'($urandom_range(0, 2) * 4);
                    w = $urandom;
                end
            endcase
            if ($urandom_range(0, 63) == 0)
                do_cycle(1, a, w, 0);
            else
                do_cycle(0, a, w, 1'($urandom_range(0, 1)));
        end

        rd(A_CTRL);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
